// File: rtl/enclave_wb_pkg.sv
// Shared types and constants for the FHE enclave Wishbone host.
// Defines the host FSM state, byte-select width helper, and the enclave
// opcode register address and field layout used by the loader/sequencer.
package enclave_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Enclave opcode register; writing it with the launch bit set starts an op.
  localparam logic [31:0] OPCODE_ADDR = 32'h3000_0000;

  // Opcode word layout: op[1:0], three 9-bit operand/result addresses, launch.
  localparam int OP_LSB       = 0;
  localparam int OP_W         = 2;
  localparam int ADDR_FIELD_W = 9;
  localparam int SRC_A_LSB    = 2;
  localparam int SRC_B_LSB    = 11;
  localparam int DST_LSB      = 20;
  localparam int LAUNCH_BIT   = 31;

  // One byte-lane select bit per byte of the data bus.
  function automatic int sel_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/enclave_wb_host.sv
// Wishbone classic single-beat initiator for the FHE enclave slave.
// Turns a valid/ready request stream into one bus cycle at a time and returns
// read data (or a timeout error) on a valid/ready response stream.
// Optional bus-wait timeout: define ENCLAVE_WB_HOST_TIMEOUT_EN.
module enclave_wb_host
  import enclave_wb_pkg::*;
#(
  parameter int  ADDR_W         = 32,
  parameter int  DATA_W         = 32,
  parameter int  TIMEOUT_CYCLES = 64,
  parameter int  IDLE_GAP       = 1,
  localparam int SEL_W          = sel_width(DATA_W)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_dat,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dat,
  output logic              rsp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  if (TIMEOUT_CYCLES < 2 || IDLE_GAP < 1) begin : g_param_check
    $error("enclave_wb_host: TIMEOUT_CYCLES must be >= 2 and IDLE_GAP >= 1");
  end

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                req_ready_q, req_ready_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

`ifdef ENCLAVE_WB_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;
  logic            rsp_err_q, rsp_err_d;
  logic            timeout_hit;

  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err     = rsp_err_q;

  // Bus-wait counter: held at zero outside a cycle, advances per unacked BUS cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
      if (state_q == IDLE)
        to_cnt_q <= '0;
      else if (state_q == BUS && !wbm_ack_i)
        to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Next-state and next-output logic for the IDLE->BUS->RSP->GAP cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    gap_cnt_d   = gap_cnt_q;
`ifdef ENCLAVE_WB_HOST_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = req_we;
          sel_d   = req_sel;
          adr_d   = req_adr;
          dat_d   = req_dat;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout expiring on the same edge.
        if (wbm_ack_i) begin
          state_d     = RSP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
`ifdef ENCLAVE_WB_HOST_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d     = RSP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
`endif
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = GAP;
          rsp_valid_d = 1'b0;
          rsp_dat_d   = '0;
          gap_cnt_d   = '0;
`ifdef ENCLAVE_WB_HOST_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(IDLE_GAP - 1))
          state_d = IDLE;
        else
          gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset clears the bus cycle asynchronously.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      req_ready_q <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      req_ready_q <= req_ready_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_enclave_wb_host.sv
// Bench for enclave_wb_host: a behavioural Wishbone slave with programmable
// ack delay, a word-array reference model of the enclave memory, and one task
// per scenario. Build with ENCLAVE_WB_HOST_TIMEOUT_EN to cover the timeout.
module tb_enclave_wb_host;
  import enclave_wb_pkg::*;

  localparam int IDLE_GAP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic        req_ready;
  logic [31:0] req_adr = '0, req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int          checks = 0;
  int          errors = 0;
  int          beats  = 0;

  // Slave model state; ack_delay 0 means the slave never acknowledges.
  int          ack_delay = 1;
  int          wait_cnt  = 0;
  logic        slv_ack   = 1'b0;
  logic        ack_force = 1'b0;
  logic [31:0] slv_dat   = '0;
  logic        cyc_prev  = 1'b0;
  logic [31:0] slv_mem [256];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  assign wbm_ack_i = slv_ack | ack_force;
  assign wbm_dat_i = slv_dat;

  enclave_wb_host #(.IDLE_GAP(IDLE_GAP)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr  (req_adr),   .req_dat  (req_dat),   .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  // Registered slave: raises ack ack_delay edges after it first sees cyc&stb.
  always @(posedge clk) begin
    if (slv_ack) begin
      slv_ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (wbm_cyc_o && wbm_stb_o && ack_delay > 0) begin
      if (wait_cnt + 1 >= ack_delay) begin
        slv_ack  <= 1'b1;
        wait_cnt <= 0;
        if (wbm_we_o) begin
          for (int b = 0; b < 4; b++)
            if (wbm_sel_o[b]) slv_mem[wbm_adr_o[9:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
          slv_dat <= 32'hDEAD_BEEF;
        end else begin
          slv_dat <= slv_mem[wbm_adr_o[9:2]];
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Bus beat counter: one count per rising edge of cyc.
  always @(negedge clk) begin
    if (wbm_cyc_o && !cyc_prev) beats <= beats + 1;
    cyc_prev <= wbm_cyc_o;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Issues one request and reports what came back. lat is the number of cycles
  // from the accept cycle to the first cycle showing rsp_valid.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int delay, input int hold,
                        output logic [31:0] r_dat, output logic r_err, output int lat,
                        output logic bus_ok, output logic hold_ok, output logic got_rsp);
    int n = 0;
    int b0;
    ack_delay = delay;
    bus_ok = 1'b1; hold_ok = 1'b1; got_rsp = 1'b0;
    r_dat = 'x; r_err = 1'bx; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    rsp_ready = 1'b0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    b0 = beats;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (!(wbm_cyc_o && wbm_stb_o && wbm_we_o == we && wbm_adr_o == adr &&
            wbm_dat_o == dat && wbm_sel_o == sel)) bus_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) return;
    got_rsp = 1'b1; r_dat = rsp_dat; r_err = rsp_err;
    if (wbm_cyc_o || wbm_stb_o) bus_ok = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== r_dat || rsp_err !== r_err || req_ready || wbm_cyc_o)
        hold_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid) hold_ok = 1'b0;
    if (beats != b0 + 1) bus_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, req_ready, rsp_valid, rsp_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b required 000000",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, req_ready, rsp_valid, rsp_err});
    end
    checks++;
    if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_dat} !== '0) begin
      errors++;
      $display("FAIL reset_data: adr=%h dat=%h sel=%h rsp_dat=%h required all 0",
               wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_dat);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_write_basic();
    logic [31:0] d; logic e, bok, hok, got; int lat;
    do_txn(1'b1, OPCODE_ADDR + 32'h4, 32'd10, 4'hF, 2, 0, d, e, lat, bok, hok, got);
    ref_mem[1] = merge(ref_mem[1], 32'd10, 4'hF);
    checks++;
    if (!(got === 1'b1 && d === 32'd0 && e === 1'b0)) begin
      errors++; $display("FAIL write_rsp: got=%b dat=%h err=%b required 1/0/0", got, d, e);
    end
    checks++;
    if (!(bok && hok)) begin
      errors++; $display("FAIL write_bus: bus_ok=%b hold_ok=%b required 1/1", bok, hok);
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL write_latency: got %0d required 4", lat); end
    checks++;
    if (slv_mem[1] !== 32'd10) begin
      errors++; $display("FAIL write_stored: got %h required 0000000a", slv_mem[1]);
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] d; logic e, bok, hok, got; int lat;
    do_txn(1'b1, OPCODE_ADDR + 32'hCC, 32'd30, 4'hF, 1, 0, d, e, lat, bok, hok, got);
    ref_mem[51] = merge(ref_mem[51], 32'd30, 4'hF);
    do_txn(1'b0, OPCODE_ADDR + 32'hCC, 32'h0, 4'hF, 1, 0, d, e, lat, bok, hok, got);
    checks++;
    if (!(got === 1'b1 && d === ref_mem[51] && e === 1'b0)) begin
      errors++; $display("FAIL read_rsp: got=%b dat=%h err=%b required 1/%h/0", got, d, e, ref_mem[51]);
    end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d required 3", lat); end
    checks++;
    if (!bok) begin errors++; $display("FAIL read_bus: bus_ok=%b required 1", bok); end
  endtask

  task automatic test_rsp_hold();
    logic [31:0] d; logic e, bok, hok, got; int lat;
    do_txn(1'b0, OPCODE_ADDR + 32'h4, 32'h0, 4'hF, 1, 5, d, e, lat, bok, hok, got);
    checks++;
    if (!(got === 1'b1 && d === ref_mem[1] && e === 1'b0)) begin
      errors++; $display("FAIL hold_rsp: got=%b dat=%h err=%b required 1/%h/0", got, d, e, ref_mem[1]);
    end
    checks++;
    if (!(hok && bok)) begin
      errors++; $display("FAIL hold_stable: hold_ok=%b bus_ok=%b required 1/1", hok, bok);
    end
  endtask

  // Two writes with req_valid and rsp_ready held high. cyc stays low through
  // the response cycle, the IDLE_GAP gap cycles and the next accept cycle.
  task automatic test_back_to_back();
    int   accepts = 0, low = 0, b0;
    logic drop = 1'b0, had_cyc = 1'b0, gap_done = 1'b0;
    ack_delay = 1;
    rsp_ready = 1'b1;
    b0 = beats;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_adr = OPCODE_ADDR + 32'h10;
    req_dat = 32'h1234_5678; req_sel = 4'hF;
    for (int c = 0; c < 20; c++) begin
      if (drop) req_valid = 1'b0;
      if (req_valid && req_ready) begin
        accepts++;
        if (accepts == 2) drop = 1'b1;
      end
      if (wbm_cyc_o) begin
        had_cyc = 1'b1;
        if (low > 0) gap_done = 1'b1;
      end else if (had_cyc && !gap_done) begin
        low++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    ref_mem[4] = merge(ref_mem[4], 32'h1234_5678, 4'hF);
    checks++;
    if (accepts != 2 || beats - b0 != 2) begin
      errors++; $display("FAIL b2b_beats: accepts=%0d beats=%0d required 2/2", accepts, beats - b0);
    end
    checks++;
    if (low != IDLE_GAP + 2) begin
      errors++; $display("FAIL b2b_gap: cyc low %0d cycles required %0d", low, IDLE_GAP + 2);
    end
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_drain: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, adr, dat, exp; logic e, bok, hok, got, we; logic [3:0] sel;
    int lat, idx, dly, hold;
    for (int t = 0; t < 24; t++) begin
      we   = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, 255);
      adr  = OPCODE_ADDR | (32'(idx) << 2);
      dat  = $urandom;
      sel  = 4'($urandom_range(1, 15));
      dly  = $urandom_range(1, 4);
      hold = $urandom_range(0, 2);
      exp  = we ? 32'd0 : ref_mem[idx];
      do_txn(we, adr, dat, sel, dly, hold, d, e, lat, bok, hok, got);
      if (we) ref_mem[idx] = merge(ref_mem[idx], dat, sel);
      checks++;
      if (!(got === 1'b1 && d === exp && e === 1'b0)) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: got=%b dat=%h err=%b required 1/%h/0", t, got, d, e, exp);
      end
      checks++;
      if (lat != dly + 2) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", t, lat, dly + 2);
      end
      checks++;
      if (!(bok && hok)) begin
        errors++; $display("FAIL rand_bus[%0d]: bus_ok=%b hold_ok=%b required 1/1", t, bok, hok);
      end
    end
  endtask

`ifdef ENCLAVE_WB_HOST_TIMEOUT_EN
  // cyc is high for 64 cycles before the abort; an ack seen on that last
  // cycle still completes normally, one cycle later it does not.
  task automatic test_timeout();
    logic [31:0] d; logic e, bok, hok, got; int lat;
    int dly[3]     = '{0, 63, 64};
    logic exp_e[3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      do_txn(1'b0, OPCODE_ADDR + 32'h14, 32'h0, 4'hF, dly[k], 0, d, e, lat, bok, hok, got);
      checks++;
      if (!(got === 1'b1 && e === exp_e[k] && d === (exp_e[k] ? 32'd0 : ref_mem[5]))) begin
        errors++;
        $display("FAIL timeout_rsp[%0d]: got=%b err=%b dat=%h required err=%b", k, got, e, d, exp_e[k]);
      end
      checks++;
      if (lat != 65) begin
        errors++; $display("FAIL timeout_len[%0d]: got %0d required 65", k, lat);
      end
    end
  endtask
`else
  task automatic test_long_wait();
    logic [31:0] d; logic e, bok, hok, got; int lat;
    do_txn(1'b0, OPCODE_ADDR + 32'h14, 32'h0, 4'hF, 100, 0, d, e, lat, bok, hok, got);
    checks++;
    if (!(got === 1'b1 && e === 1'b0 && d === ref_mem[5] && lat == 102)) begin
      errors++;
      $display("FAIL long_wait: got=%b err=%b dat=%h lat=%0d required 1/0/%h/102", got, e, d, lat, ref_mem[5]);
    end
  endtask
`endif

  task automatic test_reset_mid_bus();
    int   n = 0;
    logic quiet = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_adr = OPCODE_ADDR + 32'h8;
    req_dat = 32'hCAFE_F00D; req_sel = 4'hF;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wbm_cyc_o !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: cyc=%b required 1", wbm_cyc_o); end
    rst = 1'b1;
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, req_ready} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid_async: cyc/stb/rsp_valid/ready=%b required 0000",
               {wbm_cyc_o, wbm_stb_o, rsp_valid, req_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release: ready=%b cyc=%b required 1/0", req_ready, wbm_cyc_o);
    end
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    repeat (3) begin
      if (rsp_valid || wbm_cyc_o || !req_ready) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL rst_mid_late_ack: state disturbed, quiet=%b required 1", quiet); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 32'h5A00_0000 + 32'(i);
      ref_mem[i] = 32'h5A00_0000 + 32'(i);
    end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_rsp_hold();
    test_back_to_back();
    test_random();
`ifdef ENCLAVE_WB_HOST_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
